s_alu_bitop_engine: RTL and testbench

//  Parametrised, handshaked successor to the scalar-ALU SOP1 datapath.

---
 rtl/s_alu_bitop_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_s_alu_bitop_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_alu_bitop_engine.sv
// Scalar-ALU SOP1 engine: move, bit-manipulation and fixed-latency bit-scan ops behind a
// valid/ready request port, producing a held write-back request toward the SGPR file.
module s_alu_bitop_engine #(
    parameter int DATA_W   = 64,
    parameter int SCAN_BPC = 8,
    parameter int DST_W    = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_is64,
    input  logic [DATA_W-1:0] in_src0,
    input  logic [DST_W-1:0]  in_dst,
    input  logic              in_scc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DST_W-1:0]  out_dst,
    output logic              out_we,
    output logic              out_wr64,
    output logic              out_scc,
    output logic              out_scc_we,
    output logic              out_illegal,
    output logic              busy
);

    localparam int NMAX  = DATA_W / SCAN_BPC;
    localparam int PTR_W = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int POS_W = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_MOV      = 4'd0;
    localparam logic [3:0] OP_CMOV     = 4'd1;
    localparam logic [3:0] OP_NOT      = 4'd2;
    localparam logic [3:0] OP_BREV     = 4'd3;
    localparam logic [3:0] OP_BCNT0    = 4'd4;
    localparam logic [3:0] OP_BCNT1    = 4'd5;
    localparam logic [3:0] OP_FF0      = 4'd6;
    localparam logic [3:0] OP_FF1      = 4'd7;
    localparam logic [3:0] OP_FLBIT_B  = 4'd8;
    localparam logic [3:0] OP_FLBIT_I  = 4'd9;
    localparam logic [3:0] OP_SEXT_I8  = 4'd10;
    localparam logic [3:0] OP_SEXT_I16 = 4'd11;

    localparam logic [DATA_W-1:0] MASK32 = DATA_W'(64'h0000_0000_FFFF_FFFF);
    localparam logic [31:0]       NO_HIT = 32'hFFFF_FFFF;

    function automatic logic [POS_W-1:0] chunk_ones(input logic [SCAN_BPC-1:0] c);
        logic [POS_W-1:0] n;
        n = '0;
        for (int i = 0; i < SCAN_BPC; i++) begin
            n = n + POS_W'(c[i]);
        end
        return n;
    endfunction

    function automatic logic [POS_W-1:0] chunk_low(input logic [SCAN_BPC-1:0] c);
        logic [POS_W-1:0] p;
        p = '0;
        for (int i = SCAN_BPC - 1; i >= 0; i--) begin
            if (c[i]) p = POS_W'(i);
        end
        return p;
    endfunction

    function automatic logic [POS_W-1:0] chunk_high(input logic [SCAN_BPC-1:0] c);
        logic [POS_W-1:0] p;
        p = '0;
        for (int i = 0; i < SCAN_BPC; i++) begin
            if (c[i]) p = POS_W'(i);
        end
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    logic [1:0]        state_r;
    logic [3:0]        op_r;
    logic              is64_r;
    logic              scc_r;
    logic [DST_W-1:0]  dst_r;
    logic              msb_first_r;
    logic [DATA_W-1:0] scan_src_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  nlast_r;
    logic [POS_W-1:0]  cnt_r;
    logic              hit_r;
    logic [POS_W-1:0]  pos_r;

    logic              is64_eff_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] src_m_s;
    logic [DATA_W-1:0] not_s;
    logic [DATA_W-1:0] brev_s;
    logic [DATA_W-1:0] scan_init_s;
    logic              sign_s;
    logic              is_scan_s;
    logic [PTR_W-1:0]  nlast_init_s;

    logic [DATA_W-1:0] sc_data_s;
    logic              sc_we_s;
    logic              sc_wr64_s;
    logic              sc_scc_s;
    logic              sc_scc_we_s;
    logic              sc_ill_s;

    logic [PTR_W-1:0]    chunk_idx_s;
    logic [POS_W-1:0]    base_s;
    logic [SCAN_BPC-1:0] chunk_s;
    logic [POS_W-1:0]    cnt_next_s;
    logic                hit_next_s;
    logic [POS_W-1:0]    pos_next_s;
    logic [POS_W-1:0]    wlast_s;
    logic [31:0]         fin_res_s;
    logic                fin_scc_s;
    logic                fin_scc_we_s;

    assign in_ready = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);

    // Operand conditioning at accept: width masking, and folding every scan op into "find/count ones".
    always_comb begin
        is64_eff_s   = (DATA_W == 64) ? in_is64 : 1'b0;
        mask_s       = is64_eff_s ? {DATA_W{1'b1}} : MASK32;
        src_m_s      = in_src0 & mask_s;
        not_s        = ~in_src0 & mask_s;
        sign_s       = is64_eff_s ? in_src0[DATA_W-1] : in_src0[31];
        brev_s       = is64_eff_s ? bit_rev(src_m_s) : (bit_rev(src_m_s) >> (DATA_W - 32));
        nlast_init_s = is64_eff_s ? PTR_W'(NMAX - 1) : PTR_W'(32 / SCAN_BPC - 1);
        is_scan_s    = (in_op >= OP_BCNT0) && (in_op <= OP_FLBIT_I);
        case (in_op)
            OP_BCNT0, OP_FF0: scan_init_s = not_s;
            // XOR with the sign turns "first bit differing from sign" into "first one"; the sign bit itself becomes 0.
            OP_FLBIT_I:       scan_init_s = (in_src0 ^ {DATA_W{sign_s}}) & mask_s;
            default:          scan_init_s = src_m_s;
        endcase
    end

    // Single-cycle result, captured into the output registers on accept.
    always_comb begin
        sc_data_s   = '0;
        sc_we_s     = 1'b1;
        sc_wr64_s   = is64_eff_s;
        sc_scc_s    = in_scc;
        sc_scc_we_s = 1'b0;
        sc_ill_s    = 1'b0;
        case (in_op)
            OP_MOV:      sc_data_s = src_m_s;
            OP_CMOV:     begin sc_data_s = src_m_s; sc_we_s = in_scc; end
            OP_NOT:      begin sc_data_s = not_s; sc_scc_s = |not_s; sc_scc_we_s = 1'b1; end
            OP_BREV:     sc_data_s = brev_s;
            OP_SEXT_I8:  begin sc_data_s = DATA_W'({{24{in_src0[7]}}, in_src0[7:0]}); sc_wr64_s = 1'b0; end
            OP_SEXT_I16: begin sc_data_s = DATA_W'({{16{in_src0[15]}}, in_src0[15:0]}); sc_wr64_s = 1'b0; end
            OP_BCNT0, OP_BCNT1, OP_FF0, OP_FF1, OP_FLBIT_B, OP_FLBIT_I: sc_wr64_s = 1'b0;
            default:     begin sc_we_s = 1'b0; sc_wr64_s = 1'b0; sc_ill_s = 1'b1; end
        endcase
    end

    // One scan step: FLBIT walks chunks from the top down, everything else from the bottom up.
    always_comb begin
        chunk_idx_s = msb_first_r ? (nlast_r - ptr_r) : ptr_r;
        base_s      = POS_W'(chunk_idx_s) * POS_W'(SCAN_BPC);
        chunk_s     = SCAN_BPC'(scan_src_r >> base_s);
        cnt_next_s  = cnt_r + chunk_ones(chunk_s);
        hit_next_s  = hit_r | (|chunk_s);
        if (hit_r) begin
            pos_next_s = pos_r;
        end else if (msb_first_r) begin
            pos_next_s = base_s + chunk_high(chunk_s);
        end else begin
            pos_next_s = base_s + chunk_low(chunk_s);
        end
        wlast_s      = is64_r ? 7'd63 : 7'd31;
        fin_scc_s    = scc_r;
        fin_scc_we_s = 1'b0;
        case (op_r)
            OP_BCNT0, OP_BCNT1: begin
                fin_res_s    = 32'(cnt_next_s);
                fin_scc_s    = (cnt_next_s != 7'd0);
                fin_scc_we_s = 1'b1;
            end
            OP_FF0, OP_FF1:         fin_res_s = hit_next_s ? 32'(pos_next_s) : NO_HIT;
            OP_FLBIT_B, OP_FLBIT_I: fin_res_s = hit_next_s ? 32'(wlast_s - pos_next_s) : NO_HIT;
            default:                fin_res_s = NO_HIT;
        endcase
    end

    // Control FSM and scan accumulators; results land directly in the output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 4'd0;
            is64_r      <= 1'b0;
            scc_r       <= 1'b0;
            dst_r       <= '0;
            msb_first_r <= 1'b0;
            scan_src_r  <= '0;
            ptr_r       <= '0;
            nlast_r     <= '0;
            cnt_r       <= '0;
            hit_r       <= 1'b0;
            pos_r       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_dst     <= '0;
            out_we      <= 1'b0;
            out_wr64    <= 1'b0;
            out_scc     <= 1'b0;
            out_scc_we  <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r        <= in_op;
                        is64_r      <= is64_eff_s;
                        scc_r       <= in_scc;
                        dst_r       <= in_dst;
                        msb_first_r <= (in_op == OP_FLBIT_B) || (in_op == OP_FLBIT_I);
                        scan_src_r  <= scan_init_s;
                        nlast_r     <= nlast_init_s;
                        ptr_r       <= '0;
                        cnt_r       <= '0;
                        hit_r       <= 1'b0;
                        pos_r       <= '0;
                        if (is_scan_s) begin
                            state_r <= ST_SCAN;
                        end else begin
                            state_r     <= ST_HOLD;
                            out_valid   <= 1'b1;
                            out_data    <= sc_data_s;
                            out_dst     <= in_dst;
                            out_we      <= sc_we_s;
                            out_wr64    <= sc_wr64_s;
                            out_scc     <= sc_scc_s;
                            out_scc_we  <= sc_scc_we_s;
                            out_illegal <= sc_ill_s;
                        end
                    end
                end
                ST_SCAN: begin
                    cnt_r <= cnt_next_s;
                    hit_r <= hit_next_s;
                    pos_r <= pos_next_s;
                    if (ptr_r == nlast_r) begin
                        ptr_r       <= '0;
                        state_r     <= ST_HOLD;
                        out_valid   <= 1'b1;
                        out_data    <= DATA_W'(fin_res_s);
                        out_dst     <= dst_r;
                        out_we      <= 1'b1;
                        out_wr64    <= 1'b0;
                        out_scc     <= fin_scc_s;
                        out_scc_we  <= fin_scc_we_s;
                        out_illegal <= 1'b0;
                    end else begin
                        ptr_r <= ptr_r + PTR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_alu_bitop_engine.sv
// Scoreboard bench for s_alu_bitop_engine: a bit-level reference model predicts each result and
// its arrival cycle; an independent monitor pops and compares whenever out_valid is presented.
module tb_s_alu_bitop_engine;

    localparam int DATA_W   = 64;
    localparam int SCAN_BPC = 8;
    localparam int DST_W    = 7;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic              in_is64;
    logic [DATA_W-1:0] in_src0;
    logic [DST_W-1:0]  in_dst;
    logic              in_scc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [DST_W-1:0]  out_dst;
    logic              out_we;
    logic              out_wr64;
    logic              out_scc;
    logic              out_scc_we;
    logic              out_illegal;
    logic              busy;

    s_alu_bitop_engine #(.DATA_W(DATA_W), .SCAN_BPC(SCAN_BPC), .DST_W(DST_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is64(in_is64),
        .in_src0(in_src0), .in_dst(in_dst), .in_scc(in_scc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst),
        .out_we(out_we), .out_wr64(out_wr64), .out_scc(out_scc), .out_scc_we(out_scc_we),
        .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [6:0]  dst;
        logic        we;
        logic        wr64;
        logic        scc;
        logic        scc_we;
        logic        ill;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc = 0;
    int   ready_mode = 0;
    logic prev_valid = 1'b0;
    logic hs_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic is64, input logic [63:0] src,
                                   input logic [6:0] dst, input logic scc);
        exp_t e;
        int w;
        int cnt;
        logic sign;
        logic [63:0] m;
        logic [63:0] s;
        w = is64 ? 64 : 32;
        m = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        s = src & m;
        e.data = 64'd0; e.dst = dst; e.we = 1'b1; e.wr64 = 1'b0;
        e.scc = scc; e.scc_we = 1'b0; e.ill = 1'b0; e.due = 1;
        case (op)
            4'd0: begin e.data = s; e.wr64 = is64; end
            4'd1: begin e.data = s; e.wr64 = is64; e.we = scc; end
            4'd2: begin e.data = ~src & m; e.wr64 = is64; e.scc = (e.data != 64'd0); e.scc_we = 1'b1; end
            4'd3: begin
                for (int i = 0; i < w; i++) e.data[i] = s[w-1-i];
                e.wr64 = is64;
            end
            4'd4, 4'd5: begin
                cnt = 0;
                for (int i = 0; i < w; i++) if (s[i] == op[0]) cnt++;
                e.data = 64'(cnt); e.scc = (cnt != 0); e.scc_we = 1'b1; e.due = w / SCAN_BPC + 1;
            end
            4'd6, 4'd7: begin
                e.data = 64'hFFFF_FFFF;
                for (int i = w - 1; i >= 0; i--) if (s[i] == op[0]) e.data = 64'(i);
                e.due = w / SCAN_BPC + 1;
            end
            4'd8: begin
                e.data = 64'hFFFF_FFFF;
                for (int i = 0; i < w; i++) if (s[i]) e.data = 64'(w - 1 - i);
                e.due = w / SCAN_BPC + 1;
            end
            4'd9: begin
                sign = s[w-1];
                e.data = 64'hFFFF_FFFF;
                for (int i = 0; i < w - 1; i++) if (s[i] != sign) e.data = 64'(w - 1 - i);
                e.due = w / SCAN_BPC + 1;
            end
            4'd10: e.data = {32'd0, {24{src[7]}}, src[7:0]};
            4'd11: e.data = {32'd0, {16{src[15]}}, src[15:0]};
            default: begin e.ill = 1'b1; e.we = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic cmp_fields(input string tag, input exp_t e);
        chk({tag, "_data"}, out_data, e.data);
        chk({tag, "_dst"}, 64'(out_dst), 64'(e.dst));
        chk({tag, "_we"}, 64'(out_we), 64'(e.we));
        chk({tag, "_wr64"}, 64'(out_wr64), 64'(e.wr64));
        chk({tag, "_scc"}, 64'(out_scc), 64'(e.scc));
        chk({tag, "_scc_we"}, 64'(out_scc_we), 64'(e.scc_we));
        chk({tag, "_illegal"}, 64'(out_illegal), 64'(e.ill));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    // Monitor: new results are popped and compared, held results re-checked for stability.
    initial begin
        forever begin
            @(negedge clock);
            ncyc++;
            if (!reset_n) begin
                prev_valid = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("after_hs_valid", 64'(out_valid), 64'd0);
                    chk("after_hs_in_ready", 64'(in_ready), 64'd1);
                end
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_output: got data %0h expected no result", out_data);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("latency", 64'(ncyc), 64'(cur.due));
                        cmp_fields("result", cur);
                    end
                end else if (out_valid) begin
                    cmp_fields("held", cur);
                    chk("held_in_ready", 64'(in_ready), 64'd0);
                end
                prev_valid = out_valid;
                hs_prev = out_valid && out_ready;
            end
        end
    end

    // Consumer side: always ready, random backpressure, or stalled.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic issue(input logic [3:0] op, input logic is64, input logic [63:0] src,
                         input logic [6:0] dst, input logic scc, input bit track);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clock); #1;
        while (!in_ready && guard < 300) begin
            @(negedge clock); #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1");
        end else begin
            in_valid = 1'b1; in_op = op; in_is64 = is64; in_src0 = src; in_dst = dst; in_scc = scc;
            if (track) begin
                e = model(op, is64, src, dst, scc);
                e.due = ncyc + e.due;
                exp_q.push_back(e);
            end
            @(negedge clock); #1;
            in_valid = 1'b0;
            in_op = 4'($urandom); in_src0 = {$urandom, $urandom}; in_dst = 7'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin
            @(negedge clock); #1;
            guard++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] src;
        int          sel;
        reset_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_is64 = 1'b0;
        in_src0 = 64'd0; in_dst = 7'd0; in_scc = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_we", 64'(out_we), 64'd0);
        chk("rst_out_scc_we", 64'(out_scc_we), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_out_dst", 64'(out_dst), 64'd0);
        #1 reset_n = 1'b1;

        issue(4'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 7'd5, 1'b0, 1'b1);
        issue(4'd5, 1'b0, 64'hDEAD_BEEF_F0F0_0001, 7'd3, 1'b1, 1'b1);
        issue(4'd5, 1'b1, 64'd0, 7'd4, 1'b1, 1'b1);
        issue(4'd7, 1'b1, 64'h0000_0100_0000_0000, 7'd6, 1'b0, 1'b1);
        issue(4'd7, 1'b1, 64'd0, 7'd7, 1'b0, 1'b1);
        issue(4'd8, 1'b0, 64'h0000_0000_0000_8000, 7'd8, 1'b0, 1'b1);
        issue(4'd9, 1'b0, 64'h0000_0000_FFFF_0000, 7'd9, 1'b0, 1'b1);
        issue(4'd9, 1'b0, 64'h0000_0000_FFFF_FFFF, 7'd10, 1'b1, 1'b1);
        issue(4'd1, 1'b1, 64'h1111_2222_3333_4444, 7'd11, 1'b0, 1'b1);
        issue(4'd3, 1'b0, 64'hFFFF_FFFF_0000_0001, 7'd12, 1'b0, 1'b1);
        issue(4'd10, 1'b1, 64'hFFFF_FFFF_0000_0080, 7'd13, 1'b0, 1'b1);
        issue(4'd13, 1'b1, 64'h1234_5678_9ABC_DEF0, 7'd14, 1'b1, 1'b1);

        // Backpressure: result held for several cycles while junk requests are presented.
        drain();
        ready_mode = 2;
        issue(4'd2, 1'b0, 64'd0, 7'd9, 1'b0, 1'b1);
        in_valid = 1'b1; in_op = 4'd0; in_src0 = 64'hA5A5_A5A5_A5A5_A5A5;
        repeat (5) @(negedge clock);
        #1 in_valid = 1'b0;
        ready_mode = 0;

        // Reset during the third scan cycle of a 64-bit BCNT0 discards the in-flight result.
        drain();
        issue(4'd4, 1'b1, 64'h0F0F_0000_FFFF_1234, 7'd15, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock); #1 reset_n = 1'b0;
        @(negedge clock);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clock);

        ready_mode = 1;
        for (int t = 0; t < 250; t++) begin
            op  = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 3);
            src = (sel == 0) ? 64'd0 : (sel == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            issue(op, 1'($urandom), src, 7'($urandom), 1'($urandom), 1'b1);
        end
        ready_mode = 0;
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
